// File: rtl/seq_det_pkg.sv
// Shared encodings for the tick-qualified 1011 sequence detector.
// The FSM state value equals the number of pattern bits currently matched.
package seq_det_pkg;

    localparam logic [2:0] S0    = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S10   = 3'd2;
    localparam logic [2:0] S101  = 3'd3;
    localparam logic [2:0] S1011 = 3'd4;

    localparam logic [3:0] PATTERN = 4'b1011;

    // Advance when din matches the next expected pattern bit (MSB first).
    // Otherwise fall back to the longest suffix that is still a pattern prefix.
    function automatic logic [2:0] next_state(input logic [2:0] cur, input logic din);
        logic [2:0] nxt;
        nxt = S0;
        case (cur)
            S0:      nxt = (din == PATTERN[3]) ? S1    : S0;
            S1:      nxt = (din == PATTERN[2]) ? S10   : S1;
            S10:     nxt = (din == PATTERN[1]) ? S101  : S0;
            S101:    nxt = (din == PATTERN[0]) ? S1011 : S10;
            S1011:   nxt = din ? S1 : S10;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge strobe for a level synchronous to clk.
// The delay register resets high, so a level already high at reset release is not an edge.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) sig_q <= 1'b1;
        else       sig_q <= sig_in;
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/tick_sequence_detector.sv
// Detects the serial pattern 1011 (overlapping) on din, sampled on rising edges of clk_div,
// with a one-cycle detected pulse and a saturating match counter.
module tick_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_div,
    input  logic             din,
    input  logic             clear,
    output logic             tick,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic [2:0]       state
);

    logic [2:0]       state_q;
    logic [2:0]       state_nxt;
    logic             hit;
    logic [CNT_W-1:0] cnt_q;

    edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (clk_div),
        .rise   (tick)
    );

    always_comb begin
        state_nxt = state_q;
        if (tick) state_nxt = next_state(state_q, din);
    end

    assign hit = tick && (state_nxt == S1011);

    // Counter bumps on the same edge that raises detected; clear wins over it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S0;
            detected <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            detected <= hit;
            if (clear)
                cnt_q <= '0;
            else if (hit && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_tick_sequence_detector.sv
// Randomised and directed bench for tick_sequence_detector against a history-based model.
module tb_tick_sequence_detector;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clk_div = 1'b1;
    logic             din = 1'b0;
    logic             clear = 1'b0;
    logic             tick;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic [2:0]       state;

    int tests = 0;
    int fails = 0;

    // Reference model: last sampled bits, previous clk_div level, count, expected pulse.
    bit hist[$];
    bit m_prev = 1'b1;
    int m_cnt  = 0;
    bit m_det  = 1'b0;
    int pat[4] = '{1, 0, 1, 1};

    int pulses = 0;
    int ticks  = 0;
    int consec = 0;
    bit last_tick = 1'b0;

    tick_sequence_detector #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_div     (clk_div),
        .din         (din),
        .clear       (clear),
        .tick        (tick),
        .detected    (detected),
        .match_count (match_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    // State = length of the longest suffix of sampled history that is a prefix of 1011.
    function automatic int model_state();
        int n;
        bit ok;
        n = hist.size();
        for (int len = (n < 4 ? n : 4); len > 0; len--) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++)
                if (int'(hist[n - len + i]) != pat[i]) ok = 1'b0;
            if (ok) return len;
        end
        return 0;
    endfunction

    task automatic step(input logic cd, input logic d, input logic clr, input logic rst);
        bit exp_tick;
        @(negedge clk);
        clk_div = cd; din = d; clear = clr; reset = rst;
        #1;
        exp_tick = cd & ~m_prev;
        tests++;
        if (tick !== exp_tick) begin
            fails++;
            $display("FAIL tick @%0t: got %b expected %b", $time, tick, exp_tick);
        end
        if (tick === 1'b1) begin
            ticks++;
            if (last_tick) consec++;
        end
        last_tick = (tick === 1'b1);
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_prev = 1'b1;
            m_cnt  = 0;
            m_det  = 1'b0;
        end else begin
            m_det = 1'b0;
            if (exp_tick) begin
                hist.push_back(d);
                if (hist.size() > 4) void'(hist.pop_front());
                m_det = (model_state() == 4);
            end
            if (clr) m_cnt = 0;
            else if (m_det && m_cnt < CNT_MAX) m_cnt++;
            m_prev = cd;
        end
        #1;
        tests++;
        if (detected !== m_det || match_count !== CNT_W'(m_cnt) || state !== 3'(model_state())) begin
            fails++;
            $display("FAIL outputs @%0t: got det=%b cnt=%0d st=%0d expected det=%b cnt=%0d st=%0d",
                     $time, detected, match_count, state, m_det, m_cnt, model_state());
        end
        if (detected === 1'b1) pulses++;
    endtask

    task automatic drive_bit(input logic b, input int half, input logic clr);
        for (int i = 0; i < half; i++) step(1'b0, b, clr, 1'b0);
        for (int i = 0; i < half; i++) step(1'b1, b, clr, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        pulses = 0; ticks = 0; consec = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (detected !== 1'b0 || match_count !== '0 || state !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: got det=%b cnt=%0d st=%0d expected 0/0/0", detected, match_count, state);
        end
    endtask

    task automatic test_single_match();
        logic [3:0] seq;
        seq = 4'b1011;
        do_reset();
        for (int i = 3; i >= 0; i--) drive_bit(seq[i], 4, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (pulses != 1 || match_count !== 8'd1) begin
            fails++;
            $display("FAIL single_match: got pulses=%0d cnt=%0d expected 1/1", pulses, match_count);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] seq;
        seq = 7'b1011011;
        do_reset();
        for (int i = 6; i >= 0; i--) drive_bit(seq[i], 4, 1'b0);
        tests++;
        if (pulses != 2 || match_count !== 8'd2 || state !== 3'd4) begin
            fails++;
            $display("FAIL overlap: got pulses=%0d cnt=%0d st=%0d expected 2/2/4", pulses, match_count, state);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] seq;
        seq = 3'b101;
        do_reset();
        for (int i = 2; i >= 0; i--) drive_bit(seq[i], 4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pulses = 0;
        drive_bit(1'b1, 4, 1'b0);
        tests++;
        if (pulses != 0 || state !== 3'd1 || match_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid: got pulses=%0d st=%0d cnt=%0d expected 0/1/0", pulses, state, match_count);
        end
    endtask

    task automatic test_clk_div_high();
        do_reset();
        repeat (20) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        tests++;
        if (ticks != 0 || state !== 3'd0) begin
            fails++;
            $display("FAIL clk_div_high: got ticks=%0d st=%0d expected 0/0", ticks, state);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive_bit(1'b1, 1, 1'b0); drive_bit(1'b0, 1, 1'b0);
        drive_bit(1'b1, 1, 1'b0); drive_bit(1'b1, 1, 1'b0);
        repeat (259) begin
            drive_bit(1'b0, 1, 1'b0); drive_bit(1'b1, 1, 1'b0); drive_bit(1'b1, 1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (pulses != 260 || match_count !== 8'd255) begin
            fails++;
            $display("FAIL saturate: got pulses=%0d cnt=%0d expected 260/255", pulses, match_count);
        end
        // clear asserted during the cycle detected is high
        drive_bit(1'b0, 1, 1'b0); drive_bit(1'b1, 1, 1'b0); drive_bit(1'b1, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (match_count !== 8'd0 || pulses != 261) begin
            fails++;
            $display("FAIL clear_with_detect: got cnt=%0d pulses=%0d expected 0/261", match_count, pulses);
        end
        // clear asserted in the tick cycle that completes the match
        drive_bit(1'b0, 1, 1'b0); drive_bit(1'b1, 1, 1'b0); drive_bit(1'b1, 1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (match_count !== 8'd0 || pulses != 262) begin
            fails++;
            $display("FAIL clear_with_tick: got cnt=%0d pulses=%0d expected 0/262", match_count, pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        seq = 4'b1011;
        do_reset();
        for (int i = 3; i >= 0; i--) drive_bit(seq[i], 1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (pulses != 1 || ticks != 4 || consec != 0 || match_count !== 8'd1) begin
            fails++;
            $display("FAIL back_to_back: got pulses=%0d ticks=%0d consec=%0d cnt=%0d expected 1/4/0/1",
                     pulses, ticks, consec, match_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000)
            step(1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(15) == 0), 1'($urandom_range(63) == 0));
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_overlap();
        test_reset_mid();
        test_clk_div_high();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
